// File: rtl/sigma_uart_tx.sv
// Serial logger for 12-bit accumulator results: a small FIFO feeding a UART
// transmitter that sends each word as two back-to-back 8N1 bytes ({A,hi}, lo).
module sigma_uart_tx #(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic [11:0] data_in,
  input  logic        syn_in,
  output logic        tx,
  output logic        busy,
  output logic        ovf,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BAUD_DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic          byte_idx;
  logic [19:0]   sr;
  logic [19:0]   frame;
  logic [11:0]   head;
  logic          bit_end, word_end;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign bit_end  = (timer == TW'(BAUD_DIV - 1));
  assign word_end = (state == STOP) && byte_idx && bit_end;
  assign pop      = !empty && ((state == IDLE) || word_end);
  // A pop in the same cycle frees the slot a full-FIFO write lands in.
  assign push     = syn_in && (!full || pop);
  assign head     = mem[rd_ptr];
  // Whole word as sent, LSB first: start, byte0, stop, start, byte1, stop.
  assign frame    = {1'b1, head[7:0], 1'b0, 1'b1, 4'b1010, head[11:8], 1'b0};
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= syn_in && full && !pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      sr       <= '1;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else if (pop) begin
      state    <= START;
      timer    <= '0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      tx       <= frame[0];
      sr       <= {1'b1, frame[19:1]};
      busy     <= 1'b1;
    end else if (state != IDLE) begin
      if (bit_end) begin
        timer <= '0;
        if (word_end) begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end else begin
          tx <= sr[0];
          sr <= {1'b1, sr[19:1]};
          case (state)
            START: begin
              state   <= DATA;
              bit_cnt <= '0;
            end
            DATA: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end
            STOP: begin
              state    <= START;
              byte_idx <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sigma_uart_tx.sv
// Directed bench for sigma_uart_tx: table of single words plus multi-cycle
// sequences for back-to-back, overflow, full+pop and mid-frame reset.
module tb_sigma_uart_tx;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        res;
  logic [11:0] data_in;
  logic        syn_in;
  logic        tx, busy, ovf;
  logic [1:0]  state_dbg;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ovf_cnt = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [11:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs[5];

  sigma_uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .res(res), .data_in(data_in), .syn_in(syn_in),
    .tx(tx), .busy(busy), .ovf(ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (ovf === 1'b1) ovf_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // driver tasks
  task automatic write_burst(input logic [11:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      syn_in  = 1'b1;
      data_in = first + 12'(i);
      @(negedge clk);
    end
    syn_in = 1'b0;
  endtask

  // scoreboard: checks the exact serial waveform of n words from exp_q
  task automatic check_words(input int n);
    int waited;
    int errs;
    logic [15:0] e;
    logic [19:0] ef, rf;
    waited = 0;
    while (tx !== 1'b0 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      chk("start_bit_timeout", 32'(tx), 32'd0);
      exp_q.delete();
      return;
    end
    for (int w = 0; w < n; w++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
      ef = {1'b1, e[15:8], 1'b0, 1'b1, e[7:0], 1'b0};
      rf = '0;
      errs = 0;
      for (int k = 0; k < 20 * BD; k++) begin
        if (tx !== ef[k / BD] || busy !== 1'b1) errs++;
        if (k % BD == BD / 2) rf[k / BD] = tx;
        @(negedge clk);
      end
      chk("word_bits", 32'(rf), 32'(ef));
      chk("word_timing_busy_errs", 32'(errs), 32'd0);
    end
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int errs;
    vecs[0] = '{12'h010, 8'hA0, 8'h10};
    vecs[1] = '{12'hFF0, 8'hAF, 8'hF0};
    vecs[2] = '{12'h5A5, 8'hA5, 8'hA5};
    vecs[3] = '{12'h800, 8'hA8, 8'h00};
    vecs[4] = '{12'h7FF, 8'hA7, 8'hFF};

    res = 1'b1; syn_in = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    res = 1'b0;
    repeat (3) @(negedge clk);

    // single words from the table
    for (int v = 0; v < 5; v++) begin
      ovf_cnt = 0;
      exp_q.push_back({vecs[v].b1, vecs[v].b0});
      syn_in = 1'b1; data_in = vecs[v].data;
      @(negedge clk);
      syn_in = 1'b0;
      chk("tx_before_pop", 32'(tx), 32'd1);
      @(negedge clk);
      chk("tx_falls_one_clk_after_write", 32'(tx), 32'd0);
      check_words(1);
      chk("no_ovf_single", 32'(ovf_cnt), 32'd0);
      repeat (4) @(negedge clk);
    end

    // back-to-back: three words, 960 busy cycles, no gap
    ovf_cnt = 0;
    exp_q.push_back(16'h01A0);
    exp_q.push_back(16'h02A0);
    exp_q.push_back(16'h03A0);
    fork
      write_burst(12'h001, 3);
      check_words(3);
    join
    chk("no_ovf_b2b", 32'(ovf_cnt), 32'd0);
    repeat (4) @(negedge clk);

    // overflow: six writes, sixth dropped
    ovf_cnt = 0;
    for (int i = 1; i <= 5; i++) exp_q.push_back({8'(i), 8'hA0});
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          syn_in = 1'b1; data_in = 12'(i + 1);
          @(negedge clk);
          chk("ovf_cycle", 32'(ovf), (i == 5) ? 32'd1 : 32'd0);
        end
        syn_in = 1'b0;
        @(negedge clk);
        chk("ovf_after", 32'(ovf), 32'd0);
      end
      check_words(5);
    join
    chk("ovf_pulse_count", 32'(ovf_cnt), 32'd1);
    repeat (4) @(negedge clk);

    // full FIFO with a write in the exact end-of-word pop cycle
    ovf_cnt = 0;
    for (int i = 1; i <= 6; i++) exp_q.push_back({8'(i), 8'hA1});
    fork
      begin
        write_burst(12'h101, 5);
        repeat (316) @(negedge clk);
        syn_in = 1'b1; data_in = 12'h106;
        @(negedge clk);
        syn_in = 1'b0;
      end
      check_words(6);
    join
    chk("no_ovf_full_pop", 32'(ovf_cnt), 32'd0);
    repeat (4) @(negedge clk);

    // reset in byte0 DATA of the first of two queued words
    write_burst(12'h123, 2);
    errs = 0;
    while (tx !== 1'b0 && errs < 64) begin
      @(negedge clk);
      errs++;
    end
    repeat (BD + 5) @(negedge clk);
    chk("state_data_before_reset", 32'(state_dbg), 32'd2);
    res = 1'b1;
    #1;
    chk("reset_mid_tx", 32'(tx), 32'd1);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    chk("reset_mid_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    res = 1'b0;
    errs = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("idle_after_reset_errs", 32'(errs), 32'd0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sigma_uart_tx.md
# sigma_uart_tx

Serial output stage placed directly downstream of the 16-point accumulator. It captures each 12-bit accumulated result on its one-cycle sync pulse into a small FIFO. It then transmits each result as two 8N1 UART bytes on a single `tx` line, so the sums can be logged off-chip. The FIFO absorbs bursts while a frame is in flight.

## Interface
- `BAUD_DIV`, 16: clock cycles per UART bit; ≥ 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥ 2.

- `clk`  in  1  system clock, rising-edge.
- `res`  in  1  reset. One clock; reset is asynchronous and active-high.
- `data_in`  in  12  accumulated result, two's complement; sampled only when `syn_in`=1.
- `syn_in`  in  1  one-cycle write strobe; pushes `data_in` into the FIFO.
- `tx`  out  1  UART serial line; idles high.
- `busy`  out  1  high while a word is being shifted out.
- `ovf`  out  1  one-cycle pulse: a write was dropped because the FIFO was full.

## Operation
- Reset values: `tx`=1, `busy`=0, `ovf`=0, FIFO empty, FSM in IDLE.
  - Assertion mid-frame abandons the frame immediately (asynchronous).
  - Any FIFO contents are lost.
- Data width: the 12 bits are passed through unchanged; no sign handling is applied.
- Word framing: each word is sent as two bytes.
  - byte0 = {4'b1010, data[11:8]}; the `A` marker nibble lets the receiver resynchronise.
  - byte1 = data[7:0].
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1, giving 10 bit times. A full word is 20 bit times.
- FIFO write rules:
  - `syn_in`=1 with the FIFO not full: push.
  - `syn_in`=1 with the FIFO full and a pop in the same cycle: push accepted; count unchanged.
  - `syn_in`=1 with the FIFO full and no pop: data dropped, `ovf`=1 for the next cycle.
- FSM states and transitions:
  - IDLE: `tx`=1. If FIFO non-empty: pop into the 20-bit shift register, go to START.
  - START → DATA → STOP for byte0, then START → DATA → STOP for byte1. The byte index is tracked internally.
  - Each bit is held for exactly `BAUD_DIV` cycles (bit timer), 8 DATA bits (bit counter).
  - End of byte0 STOP: go straight to byte1 START, with no gap.
  - End of byte1 STOP with FIFO non-empty: pop and go to START, so consecutive words are back-to-back with no idle bit.
  - End of byte1 STOP with FIFO empty: go to IDLE.
- `busy` = (state ≠ IDLE).

## Timing
- All outputs are registered.
- Latency:
  - `syn_in` is sampled at edge E0 with the FIFO empty and IDLE; the entry is visible after E0.
  - The pop occurs at E1; `tx` falls and `busy` rises after E1.
- Bit boundaries: `tx` changes only at multiples of `BAUD_DIV` cycles after the start-bit edge.
  - Word duration is exactly 20·`BAUD_DIV` cycles.
  - `busy` falls at the edge ending the final stop bit when the FIFO is empty.
- Throughput: one word per 20·`BAUD_DIV` cycles. `BAUD_DIV`=16 gives 320 cycles, which matches one accumulator result per 16 samples at 20 clk/sample.
- Capacity: `FIFO_DEPTH` queued words plus 1 word in the shifter.
- `ovf` is high for exactly one cycle per dropped write. It is never asserted for accepted writes.

## Test plan
- Single word, `BAUD_DIV`=16: `data_in`=12'h010 with a one-cycle `syn_in`.
  - `tx` falls 1 clk after the write edge.
  - Bytes are 0xA0 then 0x10, each bit held 16 clk.
  - `busy` is high for 320 clk, then `tx`=1.
- Negative value: `data_in`=12'hFF0 (−16) → bytes 0xAF, 0xF0; the serial bit sequence is checked exactly.
- Back-to-back: writes 12'h001, 12'h002, 12'h003 in three consecutive cycles.
  - Three words go out contiguously with no idle gap.
  - `busy` stays high for 960 clk.
- Overflow: 6 consecutive `syn_in` cycles with values 1..6.
  - Values 1..5 are transmitted in order; 6 is dropped.
  - `ovf` pulses once, in the cycle after the 6th write.
- Full + pop coincidence: fill the FIFO, then assert `syn_in` in the exact cycle of the end-of-word pop → the write is accepted and `ovf` stays 0.
- Reset mid-frame: assert `res` during byte0 DATA of the first of two queued words.
  - `tx`=1, `busy`=0 immediately.
  - After release with no new writes, `tx` stays high.
